// File: rtl/spi_load_ctrl.sv
// SPI slave command sequencer: deserializes host frames into req/gnt word writes and
// owns the core fetch-enable level (BOOT/HALT commands).
module spi_load_ctrl #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter logic [7:0]  CMD_WRITE = 8'h02,
  parameter logic [7:0]  CMD_BOOT  = 8'h03,
  parameter logic [7:0]  CMD_HALT  = 8'h04
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              spi_sclk_i,
  input  logic              spi_cs_i,
  input  logic              spi_sdi_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  output logic              fetch_enable_o,
  output logic              frame_err_o,
  output logic              busy_o
);

  localparam int unsigned SHIFT_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CNT_W   = $clog2(SHIFT_W + 1);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StIssue, StWaitCs} state_e;

  state_e             state;
  logic               sclk_meta, sclk_sync, sclk_prev;
  logic               cs_meta, cs_sync, cs_prev;
  logic               sdi_meta, sdi_sync;
  logic [SHIFT_W-1:0] shift;
  logic [SHIFT_W-1:0] shift_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [7:0]         opcode;
  logic               sclk_rise, cs_rise;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_prev   <= 1'b1;
      sdi_meta  <= 1'b0;
      sdi_sync  <= 1'b0;
    end else begin
      sclk_meta <= spi_sclk_i;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      cs_meta   <= spi_cs_i;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      sdi_meta  <= spi_sdi_i;
      sdi_sync  <= sdi_meta;
    end
  end

  assign sclk_rise = sclk_sync & ~sclk_prev & ~cs_sync;
  assign cs_rise   = cs_sync & ~cs_prev;
  assign shift_nxt = {shift[SHIFT_W-2:0], sdi_sync};
  assign mem_we_o  = mem_req_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= StIdle;
      shift          <= '0;
      bit_cnt        <= '0;
      opcode         <= '0;
      mem_req_o      <= 1'b0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      fetch_enable_o <= 1'b0;
      frame_err_o    <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      case (state)
        // Level-sensitive entry so a cs fall coinciding with IDLE entry is not lost.
        StIdle: begin
          if (!cs_sync) begin
            state   <= StCmd;
            bit_cnt <= '0;
            busy_o  <= 1'b1;
          end
        end
        StCmd: begin
          if (cs_rise) begin
            frame_err_o <= 1'b1;
            state       <= StIdle;
            busy_o      <= 1'b0;
          end else if (sclk_rise) begin
            shift <= shift_nxt;
            if (bit_cnt == CNT_W'(7)) begin
              bit_cnt <= '0;
              opcode  <= shift_nxt[7:0];
              state   <= (shift_nxt[7:0] == CMD_WRITE) ? StAddr : StWaitCs;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        StAddr: begin
          if (cs_rise) begin
            frame_err_o <= 1'b1;
            state       <= StIdle;
            busy_o      <= 1'b0;
          end else if (sclk_rise) begin
            shift <= shift_nxt;
            if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
              bit_cnt    <= '0;
              mem_addr_o <= shift_nxt[ADDR_W-1:0];
              state      <= StData;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        StData: begin
          if (cs_rise) begin
            frame_err_o <= 1'b1;
            state       <= StIdle;
            busy_o      <= 1'b0;
          end else if (sclk_rise) begin
            shift <= shift_nxt;
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              bit_cnt     <= '0;
              mem_wdata_o <= shift_nxt[DATA_W-1:0];
              mem_req_o   <= 1'b1;
              state       <= StIssue;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        // The handshake is never aborted; a cs rise here only changes where we go next.
        StIssue: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            if (cs_sync) begin
              state  <= StIdle;
              busy_o <= 1'b0;
            end else begin
              state <= StWaitCs;
            end
          end
        end
        StWaitCs: begin
          if (cs_rise) begin
            state  <= StIdle;
            busy_o <= 1'b0;
            if (opcode == CMD_BOOT) begin
              fetch_enable_o <= 1'b1;
            end else if (opcode == CMD_HALT) begin
              fetch_enable_o <= 1'b0;
            end else if (opcode != CMD_WRITE) begin
              frame_err_o <= 1'b1;
            end
          end
        end
        default: begin
          state  <= StIdle;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_load_ctrl.sv
// Bench for spi_load_ctrl: drives randomized SPI frames and checks memory writes,
// fetch enable and frame errors against an outcome-level model of each frame.
module tb_spi_load_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        spi_sclk_i = 1'b0;
  logic        spi_cs_i = 1'b1;
  logic        spi_sdi_i = 1'b0;
  logic        mem_gnt_i = 1'b0;
  logic        mem_req_o, mem_we_o, fetch_enable_o, frame_err_o, busy_o;
  logic [31:0] mem_addr_o, mem_wdata_o;

  spi_load_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .spi_sclk_i     (spi_sclk_i),
    .spi_cs_i       (spi_cs_i),
    .spi_sdi_i      (spi_sdi_i),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .fetch_enable_o (fetch_enable_o),
    .frame_err_o    (frame_err_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int compared = 0;
  int mismatched = 0;

  // Monitor / grant generator state
  int          gnt_delay = 0;
  int          wait_cnt = 0;
  logic        prev_req = 1'b0;
  logic        prev_ferr = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;
  int          req_rises, req_cycles, unstable, ferr_cnt, ferr_long;
  logic [63:0] txq[$];
  bit          model_fe = 1'b0;

  // Sampled on the falling edge: prev_* and the current grant are what the DUT saw at
  // the preceding rising edge.
  always @(negedge clk_i) begin
    if (prev_req && mem_gnt_i) txq.push_back({prev_addr, prev_data});
    if (mem_req_o && prev_req && !mem_gnt_i &&
        (mem_addr_o !== prev_addr || mem_wdata_o !== prev_data)) unstable++;
    if (mem_we_o !== mem_req_o) unstable++;
    if (mem_req_o && !prev_req) req_rises++;
    if (mem_req_o) req_cycles++;
    if (frame_err_o) begin
      ferr_cnt++;
      if (prev_ferr) ferr_long++;
    end
    if (mem_req_o) begin
      mem_gnt_i = (wait_cnt >= gnt_delay);
      wait_cnt++;
    end else begin
      mem_gnt_i = 1'b0;
      wait_cnt  = 0;
    end
    prev_req  = mem_req_o;
    prev_addr = mem_addr_o;
    prev_data = mem_wdata_o;
    prev_ferr = frame_err_o;
  end

  task automatic clear_mon();
    txq.delete();
    req_rises  = 0;
    req_cycles = 0;
    unstable   = 0;
    ferr_cnt   = 0;
    ferr_long  = 0;
  endtask

  // Keeps pin changes 3 ns before a rising edge, never on it.
  task automatic gap(input int n);
    repeat (n) @(negedge clk_i);
    #2;
  endtask

  // Mode 0, MSB first, bits right-aligned; random sclk half period of 4..6 clk cycles.
  task automatic spi_frame(input logic [71:0] bits, input int n, input bit close);
    int h;
    h = 10 * int'($urandom_range(4, 6));
    spi_cs_i = 1'b0;
    #(h);
    for (int i = n - 1; i >= 0; i--) begin
      spi_sdi_i = bits[i];
      #(h);
      spi_sclk_i = 1'b1;
      #(h);
      spi_sclk_i = 1'b0;
    end
    if (close) begin
      #(h);
      spi_cs_i = 1'b1;
    end
  endtask

  task automatic test_reset();
    for (int pass = 0; pass < 2; pass++) begin
      compared++;
      if ({mem_req_o, mem_we_o, fetch_enable_o, frame_err_o, busy_o} !== 5'b0) begin
        mismatched++;
        $display("FAIL reset_ctrl[%0d]: req/we/fe/err/busy got %b want 00000", pass,
                 {mem_req_o, mem_we_o, fetch_enable_o, frame_err_o, busy_o});
      end
      compared++;
      if (mem_addr_o !== 32'h0) begin
        mismatched++;
        $display("FAIL reset_addr[%0d]: got %h want 0", pass, mem_addr_o);
      end
      compared++;
      if (mem_wdata_o !== 32'h0) begin
        mismatched++;
        $display("FAIL reset_wdata[%0d]: got %h want 0", pass, mem_wdata_o);
      end
      if (pass == 0) begin
        rst_ni = 1'b1;
        gap(4);
      end
    end
  endtask

  task automatic test_write_delayed();
    logic [63:0] exp;
    clear_mon();
    gnt_delay = 3;
    exp = {32'h80, 32'h0000_0fff};
    spi_frame({8'h02, exp}, 72, 1'b0);
    gap(20);
    compared++;
    if (busy_o !== 1'b1) begin
      mismatched++;
      $display("FAIL wr_busy_cs_low: got %b want 1", busy_o);
    end
    spi_cs_i = 1'b1;
    gap(6);
    compared++;
    if (busy_o !== 1'b0) begin
      mismatched++;
      $display("FAIL wr_busy_after_cs: got %b want 0", busy_o);
    end
    compared++;
    if (txq.size() != 1) begin
      mismatched++;
      $display("FAIL wr_txn_count: got %0d want 1", txq.size());
    end else begin
      compared++;
      if (txq[0] !== exp) begin
        mismatched++;
        $display("FAIL wr_txn: got %h want %h", txq[0], exp);
      end
    end
    compared++;
    if (req_rises != 1 || req_cycles != 4) begin
      mismatched++;
      $display("FAIL wr_req_shape: got rises=%0d cycles=%0d want 1/4", req_rises, req_cycles);
    end
    compared++;
    if (unstable != 0 || ferr_cnt != 0) begin
      mismatched++;
      $display("FAIL wr_stable_noerr: got unstable=%0d ferr=%0d want 0/0", unstable, ferr_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pattern[32];
    logic [63:0] exp[32];
    clear_mon();
    gnt_delay = 0;
    for (int i = 0; i < 32; i++) begin
      pattern[i] = $urandom;
      exp[i] = {32'h80 + 32'(4 * i), pattern[i]};
      spi_frame({8'h02, exp[i]}, 72, 1'b1);
      gap(4);
    end
    gap(10);
    compared++;
    if (txq.size() != 32) begin
      mismatched++;
      $display("FAIL b2b_count: got %0d want 32", txq.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        compared++;
        if (txq[i] !== exp[i]) begin
          mismatched++;
          $display("FAIL b2b_txn[%0d]: got %h want %h", i, txq[i], exp[i]);
        end
      end
    end
    compared++;
    if (req_rises != 32 || req_cycles != 32) begin
      mismatched++;
      $display("FAIL b2b_req_shape: got rises=%0d cycles=%0d want 32/32", req_rises, req_cycles);
    end
    compared++;
    if (ferr_cnt != 0 || unstable != 0) begin
      mismatched++;
      $display("FAIL b2b_noerr: got ferr=%0d unstable=%0d want 0/0", ferr_cnt, unstable);
    end
  endtask

  task automatic test_boot_halt();
    logic [7:0] seq[4];
    logic [7:0] op;
    int         exp_ferr;
    seq[0] = 8'h03;
    seq[1] = 8'h04;
    seq[2] = 8'h03;
    seq[3] = 8'h03;
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      spi_frame({64'h0, seq[i]}, 8, 1'b1);
      model_fe = (seq[i] == 8'h03);
      repeat (3) @(posedge clk_i);
      #1;
      compared++;
      if (fetch_enable_o !== model_fe) begin
        mismatched++;
        $display("FAIL fe_3cyc[%0d] op %h: got %b want %b", i, seq[i], fetch_enable_o, model_fe);
      end
      gap(5);
    end
    exp_ferr = 0;
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 2))
        0: op = 8'h03;
        1: op = 8'h04;
        default: begin
          do op = 8'($urandom_range(0, 255)); while (op >= 8'h02 && op <= 8'h04);
        end
      endcase
      if (op == 8'h03) model_fe = 1'b1;
      else if (op == 8'h04) model_fe = 1'b0;
      else exp_ferr++;
      spi_frame({64'h0, op}, 8, 1'b1);
      gap(6);
      compared++;
      if (fetch_enable_o !== model_fe) begin
        mismatched++;
        $display("FAIL fe_rand[%0d] op %h: got %b want %b", i, op, fetch_enable_o, model_fe);
      end
    end
    compared++;
    if (ferr_cnt != exp_ferr || ferr_long != 0 || req_rises != 0) begin
      mismatched++;
      $display("FAIL cmd_side_effects: got ferr=%0d long=%0d req=%0d want %0d/0/0", ferr_cnt,
               ferr_long, req_rises, exp_ferr);
    end
  endtask

  task automatic test_errors();
    clear_mon();
    spi_frame({32'h0, 8'h02, 32'h1234_5678}, 40, 1'b1);
    gap(8);
    compared++;
    if (ferr_cnt != 1 || ferr_long != 0 || req_rises != 0 || busy_o !== 1'b0) begin
      mismatched++;
      $display("FAIL trunc_40: got ferr=%0d long=%0d req=%0d busy=%b want 1/0/0/0", ferr_cnt,
               ferr_long, req_rises, busy_o);
    end
    spi_frame({64'h0, 8'h55}, 8, 1'b1);
    gap(8);
    compared++;
    if (ferr_cnt != 2 || fetch_enable_o !== model_fe) begin
      mismatched++;
      $display("FAIL unknown_55: got ferr=%0d fe=%b want 2/%b", ferr_cnt, fetch_enable_o,
               model_fe);
    end
    spi_frame({64'h0, 8'h03}, 5, 1'b1);
    gap(8);
    compared++;
    if (ferr_cnt != 3 || ferr_long != 0 || fetch_enable_o !== model_fe) begin
      mismatched++;
      $display("FAIL trunc_cmd: got ferr=%0d long=%0d fe=%b want 3/0/%b", ferr_cnt, ferr_long,
               fetch_enable_o, model_fe);
    end
  endtask

  task automatic test_cs_during_issue();
    logic [63:0] exp;
    clear_mon();
    gnt_delay = 10;
    exp = {32'h100, $urandom};
    spi_frame({8'h02, exp}, 72, 1'b0);
    gap(2);
    compared++;
    if (mem_req_o !== 1'b1) begin
      mismatched++;
      $display("FAIL issue_req_pending: got %b want 1", mem_req_o);
    end
    spi_cs_i = 1'b1;
    gap(25);
    compared++;
    if (txq.size() != 1) begin
      mismatched++;
      $display("FAIL issue_count: got %0d want 1", txq.size());
    end else begin
      compared++;
      if (txq[0] !== exp) begin
        mismatched++;
        $display("FAIL issue_txn: got %h want %h", txq[0], exp);
      end
    end
    compared++;
    if (req_cycles != 11 || ferr_cnt != 0 || busy_o !== 1'b0 || unstable != 0) begin
      mismatched++;
      $display("FAIL issue_done: got cyc=%0d ferr=%0d busy=%b unst=%0d want 11/0/0/0",
               req_cycles, ferr_cnt, busy_o, unstable);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] exp;
    spi_frame({64'h0, 8'h03}, 8, 1'b1);
    gap(5);
    model_fe = 1'b1;
    gnt_delay = 1000;
    spi_frame({8'h02, 32'h200, 32'hdead_beef}, 72, 1'b0);
    gap(4);
    compared++;
    if (mem_req_o !== 1'b1 || fetch_enable_o !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_pre: got req=%b fe=%b want 1/1", mem_req_o, fetch_enable_o);
    end
    rst_ni = 1'b0;
    #1;
    compared++;
    if (mem_req_o !== 1'b0 || fetch_enable_o !== 1'b0 || busy_o !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_async: got req=%b fe=%b busy=%b want 0/0/0", mem_req_o,
               fetch_enable_o, busy_o);
    end
    spi_cs_i = 1'b1;
    spi_sdi_i = 1'b0;
    gap(3);
    rst_ni = 1'b1;
    model_fe = 1'b0;
    gnt_delay = 0;
    gap(3);
    clear_mon();
    exp = {32'h84, $urandom};
    spi_frame({8'h02, exp}, 72, 1'b1);
    gap(8);
    compared++;
    if (txq.size() != 1) begin
      mismatched++;
      $display("FAIL rstmid_count: got %0d want 1", txq.size());
    end else begin
      compared++;
      if (txq[0] !== exp) begin
        mismatched++;
        $display("FAIL rstmid_txn: got %h want %h", txq[0], exp);
      end
    end
    compared++;
    if (req_rises != 1 || fetch_enable_o !== model_fe || busy_o !== 1'b0 || ferr_cnt != 0) begin
      mismatched++;
      $display("FAIL rstmid_after: got req=%0d fe=%b busy=%b ferr=%0d want 1/0/0/0", req_rises,
               fetch_enable_o, busy_o, ferr_cnt);
    end
  endtask

  initial begin
    clear_mon();
    gap(3);
    test_reset();
    test_write_delayed();
    gap(5);
    test_back_to_back();
    test_boot_halt();
    test_errors();
    test_cs_during_issue();
    gap(5);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
